// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: operand wakeup from two CDB ports,
// single issue per cycle. Define RS_AGE_ORDER_EN for oldest-first selection.
module rs_alu #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 rollback,
  input  logic                 issue_valid,
  input  logic [6:0]           issue_opcode,
  input  logic [2:0]           issue_funct3,
  input  logic                 issue_funct7,
  input  logic [31:0]          issue_imm,
  input  logic [31:0]          issue_pc,
  input  logic [ROB_WIDTH-1:0] issue_rob_pos,
  input  logic                 issue_rdy1,
  input  logic                 issue_rdy2,
  input  logic [31:0]          issue_val1,
  input  logic [31:0]          issue_val2,
  input  logic [ROB_WIDTH-1:0] issue_tag1,
  input  logic [ROB_WIDTH-1:0] issue_tag2,
  output logic                 full,
  input  logic                 cdb_alu_valid,
  input  logic [ROB_WIDTH-1:0] cdb_alu_rob_pos,
  input  logic [31:0]          cdb_alu_val,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_lsb_rob_pos,
  input  logic [31:0]          cdb_lsb_val,
  output logic                 alu_enable,
  output logic [6:0]           alu_opcode,
  output logic [2:0]           alu_funct3,
  output logic                 alu_funct7,
  output logic [31:0]          alu_val1,
  output logic [31:0]          alu_val2,
  output logic [31:0]          alu_imm,
  output logic [31:0]          alu_pc,
  output logic [ROB_WIDTH-1:0] alu_rob_pos
);

  localparam int IW = $clog2(RS_SIZE);

  typedef struct packed {
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7;
    logic [31:0]          imm;
    logic [31:0]          pc;
    logic [ROB_WIDTH-1:0] rob_pos;
    logic                 r1;
    logic                 r2;
    logic [31:0]          v1;
    logic [31:0]          v2;
    logic [ROB_WIDTH-1:0] q1;
    logic [ROB_WIDTH-1:0] q2;
  } ent_t;

  ent_t               ent [RS_SIZE];
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] rdy_v;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      sel_idx;
  logic               sel_ok;
  logic               d_r1;
  logic               d_r2;
  logic [31:0]        d_v1;
  logic [31:0]        d_v2;

`ifdef RS_AGE_ORDER_EN
  localparam int AW = IW + 1;
  logic [AW-1:0] age [RS_SIZE];
  logic [AW-1:0] age_cnt;

  // Counter spans twice the entry count, so a wrapped difference orders ages.
  function automatic logic older(input logic [AW-1:0] a,
                                 input logic [AW-1:0] b);
    logic [AW-1:0] d;
    d = a - b;
    return d[AW-1];
  endfunction
`endif

  assign full = &busy;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      rdy_v[i] = busy[i] & ent[i].r1 & ent[i].r2;
  end

  always_comb begin
    free_idx = '0;
    sel_idx  = '0;
    sel_ok   = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IW'(i);
`ifdef RS_AGE_ORDER_EN
    for (int i = 0; i < RS_SIZE; i++) begin
      if (rdy_v[i] && (!sel_ok || older(age[i], age[sel_idx]))) begin
        sel_ok  = 1'b1;
        sel_idx = IW'(i);
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (rdy_v[i]) begin
        sel_ok  = 1'b1;
        sel_idx = IW'(i);
      end
    end
`endif
  end

  // Bypass a result broadcast in the dispatch cycle straight into the entry.
  always_comb begin
    d_r1 = issue_rdy1;
    d_v1 = issue_val1;
    d_r2 = issue_rdy2;
    d_v2 = issue_val2;
    if (!issue_rdy1) begin
      if (cdb_alu_valid && issue_tag1 == cdb_alu_rob_pos) begin
        d_r1 = 1'b1;
        d_v1 = cdb_alu_val;
      end else if (cdb_lsb_valid && issue_tag1 == cdb_lsb_rob_pos) begin
        d_r1 = 1'b1;
        d_v1 = cdb_lsb_val;
      end
    end
    if (!issue_rdy2) begin
      if (cdb_alu_valid && issue_tag2 == cdb_alu_rob_pos) begin
        d_r2 = 1'b1;
        d_v2 = cdb_alu_val;
      end else if (cdb_lsb_valid && issue_tag2 == cdb_lsb_rob_pos) begin
        d_r2 = 1'b1;
        d_v2 = cdb_lsb_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      busy        <= '0;
      alu_enable  <= 1'b0;
      alu_opcode  <= '0;
      alu_funct3  <= '0;
      alu_funct7  <= 1'b0;
      alu_val1    <= '0;
      alu_val2    <= '0;
      alu_imm     <= '0;
      alu_pc      <= '0;
      alu_rob_pos <= '0;
`ifdef RS_AGE_ORDER_EN
      age_cnt     <= '0;
`endif
    end else if (rdy) begin
      alu_enable <= sel_ok;
      if (sel_ok) begin
        alu_opcode     <= ent[sel_idx].opcode;
        alu_funct3     <= ent[sel_idx].funct3;
        alu_funct7     <= ent[sel_idx].funct7;
        alu_val1       <= ent[sel_idx].v1;
        alu_val2       <= ent[sel_idx].v2;
        alu_imm        <= ent[sel_idx].imm;
        alu_pc         <= ent[sel_idx].pc;
        alu_rob_pos    <= ent[sel_idx].rob_pos;
        busy[sel_idx]  <= 1'b0;
      end
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !ent[i].r1) begin
          if (cdb_alu_valid && ent[i].q1 == cdb_alu_rob_pos) begin
            ent[i].r1 <= 1'b1;
            ent[i].v1 <= cdb_alu_val;
          end else if (cdb_lsb_valid && ent[i].q1 == cdb_lsb_rob_pos) begin
            ent[i].r1 <= 1'b1;
            ent[i].v1 <= cdb_lsb_val;
          end
        end
        if (busy[i] && !ent[i].r2) begin
          if (cdb_alu_valid && ent[i].q2 == cdb_alu_rob_pos) begin
            ent[i].r2 <= 1'b1;
            ent[i].v2 <= cdb_alu_val;
          end else if (cdb_lsb_valid && ent[i].q2 == cdb_lsb_rob_pos) begin
            ent[i].r2 <= 1'b1;
            ent[i].v2 <= cdb_lsb_val;
          end
        end
      end
      if (issue_valid && !full) begin
        ent[free_idx] <= '{
          opcode:  issue_opcode,
          funct3:  issue_funct3,
          funct7:  issue_funct7,
          imm:     issue_imm,
          pc:      issue_pc,
          rob_pos: issue_rob_pos,
          r1:      d_r1,
          r2:      d_r2,
          v1:      d_v1,
          v2:      d_v2,
          q1:      issue_tag1,
          q2:      issue_tag2
        };
        busy[free_idx] <= 1'b1;
`ifdef RS_AGE_ORDER_EN
        age[free_idx]  <= age_cnt;
        age_cnt        <= age_cnt + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed vectors, an entry-level behavioural model
// compared every cycle, and hand-computed literal checks.
module tb_rs_alu;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        issue_valid;
  logic [6:0]  issue_opcode;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [31:0] issue_imm, issue_pc;
  logic [3:0]  issue_rob_pos;
  logic        issue_rdy1, issue_rdy2;
  logic [31:0] issue_val1, issue_val2;
  logic [3:0]  issue_tag1, issue_tag2;
  logic        full;
  logic        cdb_alu_valid, cdb_lsb_valid;
  logic [3:0]  cdb_alu_rob_pos, cdb_lsb_rob_pos;
  logic [31:0] cdb_alu_val, cdb_lsb_val;
  logic        alu_enable;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
  logic [3:0]  alu_rob_pos;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  rs_alu #(.RS_SIZE(16), .ROB_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_imm(issue_imm), .issue_pc(issue_pc),
    .issue_rob_pos(issue_rob_pos),
    .issue_rdy1(issue_rdy1), .issue_rdy2(issue_rdy2),
    .issue_val1(issue_val1), .issue_val2(issue_val2),
    .issue_tag1(issue_tag1), .issue_tag2(issue_tag2),
    .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_pos(cdb_alu_rob_pos),
    .cdb_alu_val(cdb_alu_val),
    .cdb_lsb_valid(cdb_lsb_valid), .cdb_lsb_rob_pos(cdb_lsb_rob_pos),
    .cdb_lsb_val(cdb_lsb_val),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
  );

  typedef struct {
    bit        busy;
    bit [6:0]  op;
    bit [2:0]  f3;
    bit        f7;
    bit [31:0] imm, pc;
    bit [3:0]  rob;
    bit        r1, r2;
    bit [31:0] v1, v2;
    bit [3:0]  t1, t2;
    int        seq;
  } m_t;

  m_t        m [16];
  int        seq_ctr = 0;
  bit        e_en;
  bit [6:0]  e_op;
  bit [2:0]  e_f3;
  bit        e_f7;
  bit [31:0] e_v1, e_v2, e_imm, e_pc;
  bit [3:0]  e_rob;

  task automatic grab(input bit r, input bit [31:0] v, input bit [3:0] t,
                      output bit ro, output bit [31:0] vo);
    ro = r;
    vo = v;
    if (!r) begin
      if (cdb_alu_valid && t == cdb_alu_rob_pos) begin
        ro = 1; vo = cdb_alu_val;
      end else if (cdb_lsb_valid && t == cdb_lsb_rob_pos) begin
        ro = 1; vo = cdb_lsb_val;
      end
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return 0;
    return 1;
  endfunction

  task automatic model_step();
    int sel;
    int fr;
    bit fnow;
    if (rst || rollback) begin
      for (int i = 0; i < 16; i++) m[i].busy = 0;
      e_en = 0; e_op = 0; e_f3 = 0; e_f7 = 0;
      e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
      return;
    end
    if (!rdy) return;
    fnow = m_full();
    sel = -1;
    for (int i = 0; i < 16; i++) begin
      if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_ORDER_EN
        if (sel < 0 || m[i].seq < m[sel].seq) sel = i;
`else
        if (sel < 0) sel = i;
`endif
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (m[i].busy) begin
        grab(m[i].r1, m[i].v1, m[i].t1, m[i].r1, m[i].v1);
        grab(m[i].r2, m[i].v2, m[i].t2, m[i].r2, m[i].v2);
      end
    end
    if (issue_valid && !fnow) begin
      fr = -1;
      for (int i = 15; i >= 0; i--) if (!m[i].busy) fr = i;
      m[fr].busy = 1;
      m[fr].op = issue_opcode; m[fr].f3 = issue_funct3;
      m[fr].f7 = issue_funct7; m[fr].imm = issue_imm;
      m[fr].pc = issue_pc; m[fr].rob = issue_rob_pos;
      m[fr].t1 = issue_tag1; m[fr].t2 = issue_tag2;
      grab(issue_rdy1, issue_val1, issue_tag1, m[fr].r1, m[fr].v1);
      grab(issue_rdy2, issue_val2, issue_tag2, m[fr].r2, m[fr].v2);
      m[fr].seq = seq_ctr++;
    end
    e_en = (sel >= 0);
    if (sel >= 0) begin
      e_op = m[sel].op; e_f3 = m[sel].f3; e_f7 = m[sel].f7;
      e_v1 = m[sel].v1; e_v2 = m[sel].v2; e_imm = m[sel].imm;
      e_pc = m[sel].pc; e_rob = m[sel].rob;
      m[sel].busy = 0;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk_eq(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk_eq("model full", 32'(full), 32'(m_full()));
      chk_eq("model alu_enable", 32'(alu_enable), 32'(e_en));
      chk_eq("model alu_opcode", 32'(alu_opcode), 32'(e_op));
      chk_eq("model alu_funct3", 32'(alu_funct3), 32'(e_f3));
      chk_eq("model alu_funct7", 32'(alu_funct7), 32'(e_f7));
      chk_eq("model alu_val1", alu_val1, e_v1);
      chk_eq("model alu_val2", alu_val2, e_v2);
      chk_eq("model alu_imm", alu_imm, e_imm);
      chk_eq("model alu_pc", alu_pc, e_pc);
      chk_eq("model alu_rob_pos", 32'(alu_rob_pos), 32'(e_rob));
    end
  end

  task automatic idle();
    issue_valid   = 0;
    cdb_alu_valid = 0;
    cdb_lsb_valid = 0;
  endtask

  task automatic disp(input bit r1, input bit [31:0] v1, input bit [3:0] t1,
                      input bit r2, input bit [31:0] v2, input bit [3:0] t2,
                      input bit [3:0] rob);
    issue_valid   = 1;
    issue_opcode  = 7'h33;
    issue_funct3  = rob[2:0];
    issue_funct7  = rob[0];
    issue_imm     = 32'h20 + 32'(rob);
    issue_pc      = 32'h1000 + 32'(rob) * 4;
    issue_rob_pos = rob;
    issue_rdy1 = r1; issue_val1 = v1; issue_tag1 = t1;
    issue_rdy2 = r2; issue_val2 = v2; issue_tag2 = t2;
  endtask

  task automatic cdb_a(input bit [3:0] pos, input bit [31:0] v);
    cdb_alu_valid = 1; cdb_alu_rob_pos = pos; cdb_alu_val = v;
  endtask

  task automatic cdb_l(input bit [3:0] pos, input bit [31:0] v);
    cdb_lsb_valid = 1; cdb_lsb_rob_pos = pos; cdb_lsb_val = v;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; rdy = 1; rollback = 0;
    idle();
    disp(0, 0, 0, 0, 0, 0, 0);
    issue_valid = 0;
    cdb_alu_rob_pos = 0; cdb_alu_val = 0;
    cdb_lsb_rob_pos = 0; cdb_lsb_val = 0;
    nxt();
    nxt();
    chk_on = 1;
    chk_eq("reset full", 32'(full), 0);
    chk_eq("reset alu_enable", 32'(alu_enable), 0);
    rst = 0;

    // Both operands ready at dispatch.
    disp(1, 5, 0, 1, 7, 0, 3);
    nxt(); idle();
    chk_eq("add early enable", 32'(alu_enable), 0);
    nxt();
    chk_eq("add enable", 32'(alu_enable), 1);
    chk_eq("add val1", alu_val1, 5);
    chk_eq("add val2", alu_val2, 7);
    chk_eq("add rob", 32'(alu_rob_pos), 3);
    nxt();
    chk_eq("add single pulse", 32'(alu_enable), 0);

    // Late wakeup via LSB port.
    disp(0, 0, 2, 1, 1, 0, 4);
    nxt(); idle();
    nxt(); cdb_l(2, 32'h10);
    nxt(); idle();
    chk_eq("wake early enable", 32'(alu_enable), 0);
    nxt();
    chk_eq("wake enable", 32'(alu_enable), 1);
    chk_eq("wake val1", alu_val1, 32'h10);
    chk_eq("wake rob", 32'(alu_rob_pos), 4);

    // Bypass at dispatch.
    disp(1, 1, 0, 0, 0, 6, 5);
    cdb_a(6, 9);
    nxt(); idle();
    nxt();
    chk_eq("bypass enable", 32'(alu_enable), 1);
    chk_eq("bypass val2", alu_val2, 9);

    // Both CDB ports match: ALU port wins.
    disp(0, 0, 5, 1, 2, 0, 7);
    nxt(); idle();
    cdb_a(5, 32'hAA); cdb_l(5, 32'hBB);
    nxt(); idle();
    nxt();
    chk_eq("dual cdb val1", alu_val1, 32'hAA);

    // Freeze while rdy low.
    disp(1, 32'h11, 0, 1, 32'h22, 0, 8);
    nxt(); idle();
    rdy = 0;
    disp(1, 1, 0, 1, 1, 0, 9);
    cdb_a(1, 1);
    nxt(); nxt(); nxt();
    chk_eq("frozen enable", 32'(alu_enable), 0);
    rdy = 1; idle();
    nxt();
    chk_eq("thaw enable", 32'(alu_enable), 1);
    chk_eq("thaw rob", 32'(alu_rob_pos), 8);
    rdy = 0;
    nxt(); nxt();
    chk_eq("held enable", 32'(alu_enable), 1);
    rdy = 1;
    nxt();
    chk_eq("post hold enable", 32'(alu_enable), 0);

    // Fill every entry, each waiting on its own tag.
    for (int i = 0; i < 16; i++) begin
      disp(0, 0, 4'(i), 1, 32'(i), 0, 4'(i));
      nxt();
    end
    idle();
    chk_eq("fill full", 32'(full), 1);
    disp(1, 3, 0, 1, 4, 0, 15);
    nxt(); idle();
    chk_eq("ignored full", 32'(full), 1);
    nxt();
    chk_eq("ignored no issue", 32'(alu_enable), 0);
    cdb_a(3, 32'h33);
    nxt(); idle();
    chk_eq("woken still full", 32'(full), 1);
    disp(1, 5, 0, 1, 6, 0, 14);
    nxt(); idle();
    chk_eq("full issue enable", 32'(alu_enable), 1);
    chk_eq("full issue rob", 32'(alu_rob_pos), 3);
    chk_eq("full issue val1", alu_val1, 32'h33);
    chk_eq("full cleared", 32'(full), 0);
    nxt();
    chk_eq("blocked dispatch", 32'(alu_enable), 0);

    // Rollback with a same-cycle dispatch.
    disp(1, 1, 0, 1, 1, 0, 12);
    rollback = 1;
    nxt();
    rollback = 0; idle();
    chk_eq("rollback enable", 32'(alu_enable), 0);
    chk_eq("rollback full", 32'(full), 0);
    chk_eq("rollback rob", 32'(alu_rob_pos), 0);
    nxt();
    chk_eq("rollback discard", 32'(alu_enable), 0);
    cdb_a(0, 1); cdb_l(1, 2);
    nxt(); idle();
    nxt();
    chk_eq("rollback stale", 32'(alu_enable), 0);

    // Selection order between an older high slot and a newer low slot.
    for (int k = 0; k < 6; k++) begin
      disp(0, 0, 4'(k), 1, 32'h100 + 32'(k), 0, 4'(k));
      nxt();
    end
    idle();
    cdb_a(1, 32'h51);
    nxt(); idle();
    nxt();
    chk_eq("slot1 issue rob", 32'(alu_rob_pos), 1);
    disp(0, 0, 7, 1, 32'h108, 0, 8);
    nxt(); idle();
    cdb_a(5, 32'h55); cdb_l(7, 32'h77);
    nxt(); idle();
    nxt();
    chk_eq("order first enable", 32'(alu_enable), 1);
`ifdef RS_AGE_ORDER_EN
    chk_eq("order first rob", 32'(alu_rob_pos), 5);
`else
    chk_eq("order first rob", 32'(alu_rob_pos), 8);
`endif
    nxt();
    chk_eq("order second enable", 32'(alu_enable), 1);
`ifdef RS_AGE_ORDER_EN
    chk_eq("order second rob", 32'(alu_rob_pos), 8);
`else
    chk_eq("order second rob", 32'(alu_rob_pos), 5);
`endif
    nxt(); nxt();
    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
